gtp_blk_tx: RTL and testbench

Transmit-side framer for the 16-bit GTP block link. On a start request it reads a block of 15-bit samples from a synchronous source buffer and emits it as a control word followed by the data words, one word per clock with `gtp_vld`. It sits in front of the GTP transmitter and feeds the receive-side block FIFO at the far end, so its output must meet that FIFO's framing rules exactly.

---
 rtl/gtp_blk_tx_pkg.sv | 27 ++
 rtl/gtp_blk_tx.sv | 118 +++++++++++
 tb/tb_gtp_blk_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gtp_blk_tx_pkg.sv
// Shared definitions for the GTP block link: FSM encoding and control-word layout.
// The receive-side block FIFO uses the same control-word field constants.
package gtp_blk_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CW_FLAG_BIT = 15;
    localparam int CW_CHAN_MSB = 14;
    localparam int CW_CHAN_LSB = 9;
    localparam int CW_LEN_MSB  = 8;
    localparam int CW_LEN_LSB  = 0;

    localparam logic [15:0] CW_FLAG = 16'h8000;

    function automatic logic [15:0] make_cw(input logic [5:0] chan, input logic [8:0] len);
        logic [15:0] cw;
        cw = CW_FLAG;
        cw[CW_CHAN_MSB:CW_CHAN_LSB] = chan;
        cw[CW_LEN_MSB:CW_LEN_LSB]   = len;
        return cw;
    endfunction

endpackage

// File: rtl/gtp_blk_tx.sv
// Transmit framer: emits one control word then len source samples, one word per clock.
// gtp_vld qualifies gtp_dat every cycle; there is no backpressure, and src_dat follows src_rd by one clock.
module gtp_blk_tx
    import gtp_blk_tx_pkg::*;
#(
    parameter int unsigned GAP = 0
) (
    input  logic        gtp_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  chan,
    input  logic [8:0]  len,
    output logic        ready,
    output logic        src_rd,
    input  logic [14:0] src_dat,
    output logic [15:0] gtp_dat,
    output logic        gtp_vld,
    output logic        done,
    output logic        err_len,
    output logic        err_busy,
    output logic [15:0] blk_cnt,
    output logic [1:0]  o_dbg_state
);

    localparam logic [7:0] GAP_W = GAP[7:0];

    state_t      r_state;
    logic [8:0]  r_rem;
    logic [7:0]  r_gap;
    logic [15:0] r_dat;
    logic        r_vld;
    logic        r_done_pend;
    logic        r_done;
    logic        r_err_len;
    logic        r_err_busy;
    logic [15:0] r_blk_cnt;

    logic        w_ready;

    assign w_ready     = (r_state == ST_IDLE);
    assign ready       = w_ready;
    assign src_rd      = (w_ready & start & (len != 9'd0)) |
                         ((r_state == ST_DATA) & (r_rem > 9'd1));
    assign gtp_dat     = r_dat;
    assign gtp_vld     = r_vld;
    assign done        = r_done;
    assign err_len     = r_err_len;
    assign err_busy    = r_err_busy;
    assign blk_cnt     = r_blk_cnt;
    assign o_dbg_state = r_state;

    always_ff @(posedge gtp_clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= 9'd0;
            r_gap       <= 8'd0;
            r_dat       <= 16'd0;
            r_vld       <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_busy  <= 1'b0;
            r_blk_cnt   <= 16'd0;
        end else begin
            r_err_len   <= 1'b0;
            r_err_busy  <= start & ~w_ready;
            r_done_pend <= 1'b0;
            r_done      <= r_done_pend;
            if (r_done_pend) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_vld <= 1'b0;
                    r_dat <= 16'd0;
                    if (start) begin
                        if (len == 9'd0) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_dat   <= make_cw(chan, len);
                            r_vld   <= 1'b1;
                            r_rem   <= len;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    r_dat <= {1'b0, src_dat};
                    r_vld <= 1'b1;
                    r_rem <= r_rem - 9'd1;
                    if (r_rem == 9'd1) begin
                        r_done_pend <= 1'b1;
                        if (GAP_W != 8'd0) begin
                            r_gap   <= GAP_W;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    r_vld <= 1'b0;
                    r_dat <= 16'd0;
                    if (r_gap <= 8'd1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gtp_blk_tx.sv
// Bench for gtp_blk_tx: a per-cycle vector table on a GAP=0 instance, plus hand
// sequences for gap insertion (GAP=4 instance), maximum block and reset mid-block.
module tb_gtp_blk_tx;

    logic gtp_clk = 1'b0;
    always #5 gtp_clk = ~gtp_clk;

    logic        rst = 1'b1;

    logic        a_start = 1'b0;
    logic [5:0]  a_chan = 6'd0;
    logic [8:0]  a_len = 9'd0;
    logic        a_ready, a_src_rd, a_vld, a_done, a_el, a_eb;
    logic [14:0] a_src_dat = 15'd0;
    logic [15:0] a_dat, a_blk;
    logic [1:0]  a_st;

    logic        g_start = 1'b0;
    logic [5:0]  g_chan = 6'd0;
    logic [8:0]  g_len = 9'd0;
    logic        g_ready, g_src_rd, g_vld, g_done, g_el, g_eb;
    logic [14:0] g_src_dat = 15'd0;
    logic [15:0] g_dat, g_blk;
    logic [1:0]  g_st;

    gtp_blk_tx #(.GAP(0)) u_dut_a (
        .gtp_clk(gtp_clk), .rst(rst), .start(a_start), .chan(a_chan), .len(a_len),
        .ready(a_ready), .src_rd(a_src_rd), .src_dat(a_src_dat), .gtp_dat(a_dat),
        .gtp_vld(a_vld), .done(a_done), .err_len(a_el), .err_busy(a_eb),
        .blk_cnt(a_blk), .o_dbg_state(a_st)
    );

    gtp_blk_tx #(.GAP(4)) u_dut_g (
        .gtp_clk(gtp_clk), .rst(rst), .start(g_start), .chan(g_chan), .len(g_len),
        .ready(g_ready), .src_rd(g_src_rd), .src_dat(g_src_dat), .gtp_dat(g_dat),
        .gtp_vld(g_vld), .done(g_done), .err_len(g_el), .err_busy(g_eb),
        .blk_cnt(g_blk), .o_dbg_state(g_st)
    );

    // Source buffer models: sample k of a block is src_or | k, one clock after src_rd.
    logic        src_restart = 1'b0;
    logic [14:0] src_or = 15'd0;
    logic [14:0] src_next = 15'd0;
    always @(posedge gtp_clk) begin
        if (src_restart) begin
            src_next <= 15'd1;
        end else if (a_src_rd) begin
            a_src_dat <= src_or | src_next;
            src_next  <= src_next + 15'd1;
        end
    end
    always @(posedge gtp_clk) begin
        if (g_src_rd) g_src_dat <= g_src_dat + 15'd1;
    end

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        restart;
        logic        start;
        logic [5:0]  chan;
        logic [8:0]  len;
        logic        e_ready;
        logic        e_src_rd;
        logic        e_vld;
        logic [15:0] e_dat;
        logic        e_done;
        logic        e_el;
        logic        e_eb;
        logic [15:0] e_blk;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rs, input logic st, input logic [5:0] ch, input logic [8:0] ln,
                       input logic rdy, input logic rd, input logic vl, input logic [15:0] d,
                       input logic dn, input logic el, input logic eb, input logic [15:0] bk);
        vec_t v;
        v.restart = rs; v.start = st; v.chan = ch; v.len = ln;
        v.e_ready = rdy; v.e_src_rd = rd; v.e_vld = vl; v.e_dat = d;
        v.e_done = dn; v.e_el = el; v.e_eb = eb; v.e_blk = bk;
        vecs.push_back(v);
    endtask

    // Issues one block on instance A and checks the link words against exp_q.
    task automatic run_block(input string name, input logic [5:0] ch, input logic [8:0] ln,
                             input int budget);
        logic [15:0] got_q[$];
        int n_rd, first, last, n_done;
        n_rd = 0; first = -1; last = -1; n_done = 0;
        @(negedge gtp_clk);
        src_restart = 1'b1;
        @(negedge gtp_clk);
        src_restart = 1'b0;
        a_start = 1'b1; a_chan = ch; a_len = ln;
        #1;
        if (a_src_rd) n_rd++;
        for (int c = 1; c <= budget; c++) begin
            @(negedge gtp_clk);
            a_start = 1'b0;
            #1;
            if (a_src_rd) n_rd++;
            if (a_vld) begin
                got_q.push_back(a_dat);
                if (first < 0) first = c;
                last = c;
            end
            if (a_done) n_done++;
        end
        check({name, " word count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check({name, " word"}, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        check({name, " src_rd cycles"}, n_rd, ln);
        check({name, " cw latency"}, first, 1);
        check({name, " vld span"}, last - first + 1, ln + 1);
        check({name, " done pulses"}, n_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [9:0] gap_vld_exp;
    logic [9:0] gap_eb_exp;

    initial begin
        // Reset state.
        repeat (3) @(negedge gtp_clk);
        #1;
        check("reset a", {a_ready, a_src_rd, a_vld, a_dat, a_done, a_el, a_eb, a_blk},
              {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0});
        check("reset g", {g_ready, g_vld, g_dat, g_done, g_el, g_eb, g_blk},
              {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0});
        @(negedge gtp_clk);
        rst = 1'b0;

        // rs st ch len | ready src_rd vld dat done err_len err_busy blk
        add(1, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'd0);
        add(0, 1, 5, 3,   1, 1, 0, 16'h0000, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0,   0, 1, 1, 16'h8A03, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0,   0, 1, 1, 16'h0001, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0,   0, 0, 1, 16'h0002, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0,   1, 0, 1, 16'h0003, 0, 0, 0, 16'd0);
        add(0, 0, 0, 0,   1, 0, 0, 16'h0000, 1, 0, 0, 16'd1);
        add(0, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'd1);
        add(1, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'd1);
        add(0, 1, 1, 1,   1, 1, 0, 16'h0000, 0, 0, 0, 16'd1);
        add(0, 1, 2, 2,   0, 0, 1, 16'h8201, 0, 0, 0, 16'd1);
        add(0, 1, 2, 2,   1, 1, 1, 16'h0001, 0, 0, 1, 16'd1);
        add(0, 0, 0, 0,   0, 1, 1, 16'h8402, 1, 0, 0, 16'd2);
        add(0, 0, 0, 0,   0, 0, 1, 16'h0002, 0, 0, 0, 16'd2);
        add(0, 0, 0, 0,   1, 0, 1, 16'h0003, 0, 0, 0, 16'd2);
        add(0, 0, 0, 0,   1, 0, 0, 16'h0000, 1, 0, 0, 16'd3);
        add(0, 1, 7, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'd3);
        add(0, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 1, 0, 16'd3);
        add(0, 0, 0, 0,   1, 0, 0, 16'h0000, 0, 0, 0, 16'd3);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge gtp_clk);
            src_restart = vecs[i].restart;
            a_start = vecs[i].start;
            a_chan = vecs[i].chan;
            a_len = vecs[i].len;
            #1;
            check($sformatf("vec%0d", i),
                  {a_ready, a_src_rd, a_vld, a_dat, a_done, a_el, a_eb, a_blk},
                  {vecs[i].e_ready, vecs[i].e_src_rd, vecs[i].e_vld, vecs[i].e_dat,
                   vecs[i].e_done, vecs[i].e_el, vecs[i].e_eb, vecs[i].e_blk});
        end
        @(negedge gtp_clk);
        src_restart = 1'b0;
        a_start = 1'b0;

        // Gap insertion on the GAP=4 instance: two len=1 blocks, start held.
        gap_vld_exp = 10'b0110000110;
        gap_eb_exp  = 10'b0001111100;
        for (int c = 0; c < 10; c++) begin
            @(negedge gtp_clk);
            g_start = (c <= 6);
            g_chan = 6'd1;
            g_len = 9'd1;
            #1;
            check($sformatf("gap vld c%0d", c), g_vld, gap_vld_exp[c]);
            check($sformatf("gap err_busy c%0d", c), g_eb, gap_eb_exp[c]);
            if (c == 1) check("gap cw", g_dat, 16'h8201);
        end
        @(negedge gtp_clk);
        g_start = 1'b0;
        repeat (6) @(negedge gtp_clk);
        #1;
        check("gap blk_cnt", g_blk, 16'd2);

        // Maximum block: chan 63, len 511, every sample has bit 14 set.
        src_or = 15'h4000;
        exp_q.push_back(16'hFFFF);
        for (int k = 1; k <= 511; k++) exp_q.push_back(16'h4000 | 16'(k));
        run_block("max", 6'd63, 9'd511, 520);
        check("max blk_cnt", a_blk, 16'd4);
        src_or = 15'h0000;

        // Reset after 10 of 100 words, then a clean len=2 block.
        @(negedge gtp_clk);
        src_restart = 1'b1;
        @(negedge gtp_clk);
        src_restart = 1'b0;
        a_start = 1'b1; a_chan = 6'd3; a_len = 9'd100;
        for (int c = 1; c <= 11; c++) begin
            @(negedge gtp_clk);
            a_start = 1'b0;
        end
        #1;
        check("pre-rst word10", {a_vld, a_dat, a_blk}, {1'b1, 16'h000A, 16'd4});
        rst = 1'b1;
        @(negedge gtp_clk);
        rst = 1'b0;
        #1;
        check("post-rst outputs", {a_ready, a_vld, a_dat, a_done, a_el, a_eb, a_blk},
              {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0});
        exp_q.push_back(16'h9202);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        run_block("post-rst blk", 6'd9, 9'd2, 8);
        check("post-rst blk_cnt", a_blk, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
